// File: rtl/sha256_msg_sequencer.sv
// Multi-block SHA-256 message controller: feeds padded blocks to sha256_core,
// chains intermediate hashes, and presents the final digest on a valid/ready port.
module sha256_msg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [511:0]       blk_data,
    input  logic               blk_last,
    output logic               core_start,
    output logic [511:0]       core_block,
    output logic [255:0]       core_hash_init,
    output logic               core_use_init,
    input  logic [255:0]       core_hash_out,
    input  logic               core_ready,
    output logic [255:0]       digest,
    output logic               digest_valid,
    input  logic               digest_ready,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   block_count
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_CAPT,
        S_OUT,
        S_ERR
    } state_t;

    state_t          r_state;
    logic            r_first;
    logic            r_last;
    logic [WD_W-1:0] r_wdog;
    logic            w_accept;
    logic            w_wd_expire;

    assign w_accept    = blk_valid && blk_ready;
    assign w_wd_expire = (r_wdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_first        <= 1'b1;
            r_last         <= 1'b0;
            r_wdog         <= '0;
            blk_ready      <= 1'b0;
            core_start     <= 1'b0;
            core_block     <= '0;
            core_hash_init <= '0;
            core_use_init  <= 1'b0;
            digest         <= '0;
            digest_valid   <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            block_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        core_block    <= blk_data;
                        r_last        <= blk_last;
                        core_use_init <= !r_first;
                        core_start    <= 1'b1;
                        blk_ready     <= 1'b0;
                        busy          <= 1'b1;
                        r_wdog        <= '0;
                        r_state       <= S_ARM;
                    end else begin
                        blk_ready <= !digest_valid && !err;
                    end
                end

                // ready may still be high from the previous block; wait for the core to drop it
                S_ARM, S_RUN: begin
                    if (w_wd_expire) begin
                        core_start   <= 1'b0;
                        err          <= 1'b1;
                        blk_ready    <= 1'b0;
                        digest_valid <= 1'b0;
                        r_state      <= S_ERR;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                        if (r_state == S_ARM && !core_ready) begin
                            r_state <= S_RUN;
                        end else if (r_state == S_RUN && core_ready) begin
                            core_start <= 1'b0;
                            r_state    <= S_CAPT;
                        end
                    end
                end

                S_CAPT: begin
                    core_hash_init <= core_hash_out;
                    block_count    <= block_count + CNT_W'(1);
                    if (r_last) begin
                        digest       <= core_hash_out;
                        digest_valid <= 1'b1;
                        r_first      <= 1'b1;
                        r_state      <= S_OUT;
                    end else begin
                        r_first   <= 1'b0;
                        blk_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                S_OUT: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        block_count  <= '0;
                        blk_ready    <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                S_ERR: begin
                    core_start   <= 1'b0;
                    blk_ready    <= 1'b0;
                    digest_valid <= 1'b0;
                    err          <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core model
// and a digest scoreboard; a second instance exercises the watchdog.
module tb_sha256_msg_sequencer;

    localparam int LAT = 5;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [255:0] dig;
        int           cnt;
    } exp_t;

    typedef struct {
        logic         use_init;
        logic [255:0] hinit;
        int           gap;
    } start_ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_last = 1'b0;
    logic         core_start;
    logic [511:0] core_block;
    logic [255:0] core_hash_init;
    logic         core_use_init;
    logic [255:0] core_hash_out;
    logic         core_ready;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready = 1'b0;
    logic         busy;
    logic         err;
    logic [15:0]  block_count;

    // watchdog DUT signals
    logic         rst2 = 1'b1;
    logic         blk_valid2 = 1'b0;
    logic         blk_ready2;
    logic         core_start2;
    logic [511:0] core_block2;
    logic [255:0] core_hash_init2;
    logic         core_use_init2;
    logic [255:0] core_hash_out2 = '0;
    logic         core_ready2 = 1'b0;
    logic [255:0] digest2;
    logic         digest_valid2;
    logic         busy2;
    logic         err2;
    logic [15:0]  block_count2;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t         exp_q[$];
    start_ev_t    ev_q[$];
    logic [255:0] done_q[$];

    sha256_msg_sequencer #(.TIMEOUT_CYCLES(1023), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .core_start(core_start), .core_block(core_block), .core_hash_init(core_hash_init),
        .core_use_init(core_use_init), .core_hash_out(core_hash_out), .core_ready(core_ready),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .busy(busy), .err(err), .block_count(block_count)
    );

    sha256_msg_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut_wd (
        .clk(clk), .rst(rst2),
        .blk_valid(blk_valid2), .blk_ready(blk_ready2), .blk_data(ABC_BLK), .blk_last(1'b1),
        .core_start(core_start2), .core_block(core_block2), .core_hash_init(core_hash_init2),
        .core_use_init(core_use_init2), .core_hash_out(core_hash_out2), .core_ready(core_ready2),
        .digest(digest2), .digest_valid(digest_valid2), .digest_ready(1'b0),
        .busy(busy2), .err(err2), .block_count(block_count2)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Core model: ready drops one cycle after start, result after LAT cycles, holds DONE until start falls
    int           c_st = 0;
    int           c_cnt = 0;
    int           low_cnt = 0;
    logic [255:0] c_res = '0;
    start_ev_t    m_ev;

    always @(posedge clk) begin
        if (rst) begin
            c_st          <= 0;
            c_cnt         <= 0;
            low_cnt       <= 0;
            core_ready    <= 1'b1;
            core_hash_out <= '0;
        end else begin
            if (!core_start) low_cnt <= low_cnt + 1;
            case (c_st)
                0: if (core_start) begin
                    m_ev.use_init = core_use_init;
                    m_ev.hinit    = core_hash_init;
                    m_ev.gap      = low_cnt;
                    ev_q.push_back(m_ev);
                    c_res      <= sha_compress(core_use_init ? core_hash_init : IV, core_block);
                    core_ready <= 1'b0;
                    c_cnt      <= 0;
                    low_cnt    <= 0;
                    c_st       <= 1;
                end
                1: if (c_cnt == LAT - 1) begin
                    core_hash_out <= c_res;
                    core_ready    <= 1'b1;
                    done_q.push_back(c_res);
                    c_st          <= 2;
                end else begin
                    c_cnt <= c_cnt + 1;
                end
                default: if (!core_start) c_st <= 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_block(input string tag, input logic [511:0] data, input logic last);
        bit done = 0;
        blk_valid = 1'b1;
        blk_data  = data;
        blk_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (blk_ready) done = 1;
            tick();
        end
        blk_valid = 1'b0;
        if (!done) check({tag, "_accept_timeout"}, 256'(0), 256'(1));
    endtask

    task automatic take_digest(input string tag, input int hold);
        bit   seen = 0;
        exp_t e;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (digest_valid) seen = 1;
            else tick();
        end
        if (!seen) begin
            check({tag, "_digest_timeout"}, 256'(0), 256'(1));
            return;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_valid_held"}, 256'(digest_valid), 256'(1));
            check({tag, "_blk_ready_low"}, 256'(blk_ready), 256'(0));
        end
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_digest"}, 256'(0), 256'(1));
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_digest"}, digest, e.dig);
        check({tag, "_block_count"}, 256'(block_count), 256'(e.cnt));
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check({tag, "_valid_cleared"}, 256'(digest_valid), 256'(0));
        check({tag, "_count_cleared"}, 256'(block_count), 256'(0));
        check({tag, "_idle"}, 256'(busy), 256'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 256'({blk_ready, core_start, core_use_init, digest_valid, busy, err}), 256'(0));
        check({tag, "_core_block"}, 256'(core_block != '0), 256'(0));
        check({tag, "_hash_init"}, core_hash_init, 256'(0));
        check({tag, "_digest"}, digest, 256'(0));
        check({tag, "_block_count"}, 256'(block_count), 256'(0));
    endtask

    initial begin
        start_ev_t ev0, ev1;
        bit        hit;

        tick();
        tick();
        check_reset_vals("reset");
        rst  = 1'b0;
        rst2 = 1'b0;
        tick();

        // single block "abc", also checks stale core_ready at ARM entry is ignored
        ev_q.delete();
        exp_q.push_back('{dig: ABC_DIG, cnt: 1});
        send_block("abc", ABC_BLK, 1'b1);
        check("abc_stale_ready_pre", 256'(core_ready), 256'(1));
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("abc_no_early_capture", 256'(digest_valid), 256'(0));
        end
        take_digest("abc", 5);
        check("abc_starts", 256'(ev_q.size()), 256'(1));
        if (ev_q.size() > 0) begin
            ev0 = ev_q.pop_front();
            check("abc_use_init", 256'(ev0.use_init), 256'(0));
        end

        // two-block message with chained hash
        ev_q.delete();
        done_q.delete();
        exp_q.push_back('{dig: TWO_DIG, cnt: 2});
        send_block("two_b1", TWO_B1, 1'b0);
        send_block("two_b2", TWO_B2, 1'b1);
        take_digest("two", 0);
        check("two_starts", 256'(ev_q.size()), 256'(2));
        if (ev_q.size() == 2 && done_q.size() >= 1) begin
            ev0 = ev_q.pop_front();
            ev1 = ev_q.pop_front();
            check("two_b1_use_init", 256'(ev0.use_init), 256'(0));
            check("two_b2_use_init", 256'(ev1.use_init), 256'(1));
            check("two_b2_hash_init", ev1.hinit, done_q[0]);
            check("two_start_gap", 256'(ev1.gap >= 1), 256'(1));
        end

        // back-to-back messages with the digest held off for 20 cycles
        ev_q.delete();
        exp_q.push_back('{dig: ABC_DIG, cnt: 1});
        exp_q.push_back('{dig: ABC_DIG, cnt: 1});
        send_block("b2b_1", ABC_BLK, 1'b1);
        blk_valid = 1'b1;
        take_digest("b2b_1", 20);
        send_block("b2b_2", ABC_BLK, 1'b1);
        take_digest("b2b_2", 0);
        check("b2b_starts", 256'(ev_q.size()), 256'(2));
        if (ev_q.size() == 2) begin
            ev0 = ev_q.pop_front();
            ev1 = ev_q.pop_front();
            check("b2b_start_gap", 256'(ev1.gap >= 1), 256'(1));
            check("b2b_2_use_init", 256'(ev1.use_init), 256'(0));
        end

        // reset during RUN of the second block of a two-block message
        ev_q.delete();
        send_block("rst_b1", TWO_B1, 1'b0);
        send_block("rst_b2", TWO_B2, 1'b1);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (ev_q.size() == 2 && !core_ready) hit = 1;
            else tick();
        end
        check("rst_reached_run", 256'(hit), 256'(1));
        rst = 1'b1;
        tick();
        check_reset_vals("midrun_reset");
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            check("rst_no_digest", 256'(digest_valid), 256'(0));
        end
        ev_q.delete();
        done_q.delete();
        exp_q.push_back('{dig: ABC_DIG, cnt: 1});
        send_block("post_rst", ABC_BLK, 1'b1);
        take_digest("post_rst", 1);
        if (ev_q.size() > 0) begin
            ev0 = ev_q.pop_front();
            check("post_rst_use_init", 256'(ev0.use_init), 256'(0));
        end else begin
            check("post_rst_start", 256'(0), 256'(1));
        end
        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        // watchdog with a core that never completes
        blk_valid2 = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (busy2) hit = 1;
        end
        check("wd_accepted", 256'(hit), 256'(1));
        repeat (7) tick();
        check("wd_not_yet", 256'({err2, core_start2}), 256'(2'b01));
        tick();
        check("wd_err", 256'(err2), 256'(1));
        check("wd_start_low", 256'(core_start2), 256'(0));
        check("wd_blk_ready_low", 256'({blk_ready2, digest_valid2}), 256'(0));
        repeat (10) tick();
        check("wd_sticky", 256'({err2, busy2, blk_ready2, core_start2}), 256'(4'b1100));
        rst2 = 1'b1;
        blk_valid2 = 1'b0;
        tick();
        check("wd_reset_clears", 256'({err2, busy2}), 256'(0));
        rst2 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
